// File: rtl/ov7670_capture_pkg.sv
// Shared constants, FSM encoding and pattern helper for the OV7670 capture stage.
package ov7670_capture_pkg;

    localparam int c_in_cols     = 160;
    localparam int c_in_rows     = 120;
    localparam int c_img_cols    = c_in_cols / 2;
    localparam int c_img_rows    = c_in_rows / 2;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = 13;
    localparam int c_nb_buf      = 12;

    localparam int c_nib_w = 4;
    localparam int c_r_lsb = 8;
    localparam int c_g_lsb = 4;
    localparam int c_b_lsb = 0;

    typedef enum logic [1:0] {
        WAIT_VS_HI = 2'd0,
        WAIT_VS_LO = 2'd1,
        CAPTURE    = 2'd2
    } cap_state_t;

    function automatic logic [c_nb_buf-1:0] bar_pixel(input logic [2:0] bar);
        return {{c_nib_w{bar[2]}}, {c_nib_w{bar[1]}}, {c_nib_w{bar[0]}}};
    endfunction

endpackage

// File: rtl/ov7670_sync_edge.sv
// Two-flop synchroniser with a third flop for rising/falling edge detection.
module ov7670_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s_p0, s_p1, s_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_p0 <= 1'b0;
            s_p1 <= 1'b0;
            s_p2 <= 1'b0;
        end else begin
            s_p0 <= din;
            s_p1 <= s_p0;
            s_p2 <= s_p1;
        end
    end

    assign sync = s_p1;
    assign rise = s_p1 & ~s_p2;
    assign fall = s_p2 & ~s_p1;

endmodule

// File: rtl/ov7670_capture.sv
// Captures the OV7670 byte stream, decimates 2:1 in both axes and writes 12-bit
// pixels in raster order into the frame buffer.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int in_cols = c_in_cols,
    parameter int in_rows = c_in_rows
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ov7670_pclk,
    input  logic                     ov7670_href,
    input  logic                     ov7670_vsync,
    input  logic [7:0]               ov7670_d,
    input  logic                     rgbmode,
    input  logic                     testmode,
    input  logic [2:0]               rgbfilter,
    output logic                     frame_we,
    output logic [c_nb_img_pxls-1:0] frame_addr,
    output logic [c_nb_buf-1:0]      frame_pixel,
    output logic                     frame_done
);

    localparam int img_pxls = (in_cols / 2) * (in_rows / 2);
    localparam int col_w    = $clog2(in_cols + 1);
    localparam int row_w    = $clog2(in_rows + 1);

    logic pclk_s, pclk_rise, pclk_fall;
    logic href_s, href_rise, href_fall;
    logic vsync_s, vsync_rise, vsync_fall;
    logic unused_edges;

    ov7670_sync_edge u_pclk (.clk(clk), .rst(rst), .din(ov7670_pclk),
                             .sync(pclk_s), .rise(pclk_rise), .fall(pclk_fall));
    ov7670_sync_edge u_href (.clk(clk), .rst(rst), .din(ov7670_href),
                             .sync(href_s), .rise(href_rise), .fall(href_fall));
    ov7670_sync_edge u_vsync (.clk(clk), .rst(rst), .din(ov7670_vsync),
                              .sync(vsync_s), .rise(vsync_rise), .fall(vsync_fall));

    assign unused_edges = ^{pclk_s, pclk_fall, href_rise};

    // data byte: same two-flop depth as the control lines so it stays aligned
    logic [7:0] d_p0, d_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_p0 <= '0;
            d_p1 <= '0;
        end else begin
            d_p0 <= ov7670_d;
            d_p1 <= d_p0;
        end
    end

    cap_state_t               state;
    logic                     rgb_q, test_q;
    logic [2:0]               filt_q;
    logic [col_w-1:0]         in_col;
    logic [row_w-1:0]         in_row;
    logic                     phase;
    logic [7:0]               b0;
    logic [c_nb_img_pxls-1:0] addr_cnt;
    logic                     byte_stb, wr_ok;

    function automatic logic [c_nb_buf-1:0] format_pixel(
        input logic             rgb,
        input logic             tst,
        input logic [2:0]       filt,
        input logic [7:0]       hi,
        input logic [7:0]       lo,
        input logic [col_w-1:0] col
    );
        logic [c_nb_buf-1:0] px;
        logic [2:0]          bar;
        bar = 3'((col >> 1) / 10);
        if (tst)
            px = bar_pixel(bar);
        else if (rgb)
            px = {hi[3:0], lo};
        else
            px = {4'h0, hi};
        // channel masking only makes sense for RGB; YUV carries luma in [7:0]
        if (rgb) begin
            if (!filt[2]) px[c_r_lsb +: c_nib_w] = '0;
            if (!filt[1]) px[c_g_lsb +: c_nib_w] = '0;
            if (!filt[0]) px[c_b_lsb +: c_nib_w] = '0;
        end
        return px;
    endfunction

    assign byte_stb = pclk_rise & href_s;
    assign wr_ok    = byte_stb & phase & ~in_col[0] & ~in_row[0]
                    & (in_col < col_w'(in_cols))
                    & (in_row < row_w'(in_rows))
                    & (addr_cnt < c_nb_img_pxls'(img_pxls));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= WAIT_VS_HI;
            rgb_q       <= 1'b0;
            test_q      <= 1'b0;
            filt_q      <= '0;
            in_col      <= '0;
            in_row      <= '0;
            phase       <= 1'b0;
            b0          <= '0;
            addr_cnt    <= '0;
            frame_we    <= 1'b0;
            frame_addr  <= '0;
            frame_pixel <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_we   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                WAIT_VS_HI: begin
                    if (vsync_s) state <= WAIT_VS_LO;
                end
                WAIT_VS_LO: begin
                    if (vsync_fall) begin
                        rgb_q    <= rgbmode;
                        test_q   <= testmode;
                        filt_q   <= rgbfilter;
                        in_col   <= '0;
                        in_row   <= '0;
                        phase    <= 1'b0;
                        addr_cnt <= '0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= WAIT_VS_LO;
                    end else if (href_fall) begin
                        in_col <= '0;
                        phase  <= 1'b0;
                        if (in_row < row_w'(in_rows)) in_row <= in_row + 1'b1;
                    end else if (byte_stb) begin
                        if (!phase) begin
                            b0    <= d_p1;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (in_col < col_w'(in_cols)) in_col <= in_col + 1'b1;
                            if (wr_ok) begin
                                frame_we    <= 1'b1;
                                frame_addr  <= addr_cnt;
                                frame_pixel <= format_pixel(rgb_q, test_q, filt_q, b0, d_p1, in_col);
                                addr_cnt    <= addr_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= WAIT_VS_HI;
            endcase
        end
    end

endmodule
